spike_synapse: RTL and testbench
================================

SPIKE_SYNAPSE -- requirements
Module: spike_synapse

Interface
REQ-001 SHALL have parameter N_IN, default 8: number of presynaptic spike inputs, legal range 2..8.
REQ-002 SHALL have parameter DECAY_SHIFT, default 1: right-shift applied to the current each enabled cycle, legal range 1..4.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: when high, the current updates; when low, the current holds.
REQ-006 SHALL have port spikes_in, input, N_IN: one bit per presynaptic neuron, sampled each cycle.
REQ-007 SHALL have port cfg_valid, input, 1: weight-write request.
REQ-008 SHALL have port cfg_ready, output, 1: write may be accepted this cycle.
REQ-009 SHALL have port cfg_addr, input, 3: weight index.
REQ-010 SHALL have port cfg_weight, input, 8: unsigned weight value.
REQ-011 SHALL have port cfg_err, output, 1: one-cycle pulse on an accepted write with an illegal address.
REQ-012 SHALL have port current, output, 8: registered synaptic current driving the downstream neuron current input.
REQ-013 SHALL have port active, output, 1: high when current is nonzero (combinational from the register).

Function
REQ-014 SHALL hold N_IN unsigned 8-bit weight registers.
REQ-015 SHALL compute the update as sum = (current >> DECAY_SHIFT) + sum of weight[i] over all i with spikes_in[i]=1, using an intermediate of at least 12 bits.
REQ-016 SHALL saturate the update: current_next = 255 if sum > 255, else sum; no wrap-around.
REQ-017 SHALL register current_next into current on the edge where en=1; spikes sampled at edge k affect current at edge k (one-cycle latency).
REQ-018 SHALL leave current unchanged and ignore spikes_in while en=0; weight writes still proceed.
REQ-019 SHALL implement cfg FSM states IDLE (cfg_ready=1) and BUSY (cfg_ready=0); cfg_ready is a registered output.
REQ-020 SHALL accept a write when cfg_valid=1 and cfg_ready=1 at a clock edge, then move IDLE->BUSY.
REQ-021 SHALL move BUSY->IDLE unconditionally on the next edge (one dead cycle between writes; maximum write rate one per 2 cycles).
REQ-022 SHALL write weight[cfg_addr] on acceptance when cfg_addr < N_IN; the new value is visible to the sum from the following cycle.
REQ-023 SHALL use the old weight value for a spike sampled in the same cycle a write to that index is accepted.
REQ-024 SHALL, on acceptance with cfg_addr >= N_IN, modify no weight, pulse cfg_err high for exactly the next cycle, and still complete the handshake (IDLE->BUSY).
REQ-025 SHALL ignore cfg_valid while in BUSY; requesters hold cfg_valid and data until acceptance.

Reset
REQ-026 SHALL, while rst_n=0 at an edge, set current=0, all weights=0, cfg_err=0, FSM=BUSY (cfg_ready=0).
REQ-027 SHALL enter IDLE on the first edge with rst_n=1, so cfg_ready=1 one cycle after reset release.
REQ-028 SHALL treat reset asserted mid-write or mid-decay as overriding: the pending write is discarded and current is cleared on that edge.

Verification
REQ-029 SHALL be verified for reset: assert rst_n=0 for 2 cycles -> current=0, active=0, cfg_ready=0; release -> cfg_ready=1 after 1 cycle.
REQ-030 SHALL be verified for decay: write weight[2]=40, en=1, single pulse spikes_in=0x04 -> current sequence 40,20,10,5,2,1,0; active falls with 0.
REQ-031 SHALL be verified for saturation: all weights=200, spikes_in=0xFF held -> current=255 and stays 255; release spikes -> 127,63,...
REQ-032 SHALL be verified for same-cycle collision: weight[0]=50, accept write weight[0]=10 with spikes_in=0x01 in the same cycle -> current=50; next spike -> current=(50>>1)+10=35.
REQ-033 SHALL be verified for handshake and range: cfg_valid held for 2 writes -> accepts 2 cycles apart with cfg_ready low between; N_IN=6 with addr 7 -> cfg_err pulse for 1 cycle and weights unchanged.
REQ-034 SHALL be verified for enable and reset: en=0 with spikes -> current holds; rst_n=0 mid-operation -> current=0 and all weights=0 (a spike after release yields current=0).

Source files
------------

// File: rtl/spike_synapse.sv
// Synaptic current integrator for a spiking neuron.
// Each enabled cycle the current decays by a right shift, and the weights of all
// spiking inputs are added to it, saturating at 255. A small two-state handshake
// loads the weights, accepting at most one write every two cycles.
module spike_synapse #(
    parameter int unsigned N_IN        = 8,
    parameter int unsigned DECAY_SHIFT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_IN-1:0] spikes_in,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [2:0]      cfg_addr,
    input  logic [7:0]      cfg_weight,
    output logic            cfg_err,
    output logic [7:0]      current,
    output logic            active
);

    localparam int unsigned W_W   = 8;
    localparam int unsigned SUM_W = 12;
    localparam int unsigned ADR_W = 4;

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic             state;
    logic             state_next;
    logic [W_W-1:0]   weights [N_IN];
    logic             accept_c;
    logic             addr_ok_c;
    logic [SUM_W-1:0] sum_c;
    logic [W_W-1:0]   current_next_c;

    // Handshake decode: a write lands when requested while the port is idle
    always_comb begin
        accept_c  = cfg_valid && cfg_ready;
        addr_ok_c = (ADR_W'({1'b0, cfg_addr}) < ADR_W'(N_IN));
    end

    // Next-state logic for the configuration port
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = BUSY;
            BUSY:    state_next = IDLE;
            default: state_next = BUSY;
        endcase
    end

    // Configuration FSM state with registered ready and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= BUSY;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cfg_ready <= (state_next == IDLE);
            cfg_err   <= accept_c && !addr_ok_c;
        end
    end

    // Weight storage; the current edge still sums with the old weight value
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (!rst_n) begin
                weights[i] <= '0;
            end else if (accept_c && addr_ok_c && (cfg_addr == 3'(i))) begin
                weights[i] <= cfg_weight;
            end
        end
    end

    // Decayed current plus weights of all spiking inputs, clamped to 8 bits
    always_comb begin
        sum_c = SUM_W'(current >> DECAY_SHIFT);
        for (int i = 0; i < N_IN; i++) begin
            if (spikes_in[i]) sum_c = sum_c + SUM_W'(weights[i]);
        end
        current_next_c = (sum_c > SUM_W'(255)) ? 8'hFF : sum_c[W_W-1:0];
    end

    // Current register; frozen while disabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            current <= '0;
        end else if (en) begin
            current <= current_next_c;
        end
    end

    assign active = (current != '0);

endmodule

// File: tb/tb_spike_synapse.sv
// Bench for spike_synapse: a reference model computes the expected outputs for
// every clock edge and queues them; a monitor compares after each edge.
module tb_spike_synapse;

    localparam int N  = 6;
    localparam int DS = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] spikes_in;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [2:0]   cfg_addr;
    logic [7:0]   cfg_weight;
    logic         cfg_err;
    logic [7:0]   current;
    logic         active;

    typedef struct {
        int cur;
        bit act;
        bit rdy;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    spike_synapse #(.N_IN(N), .DECAY_SHIFT(DS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spikes_in  (spikes_in),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_weight (cfg_weight),
        .cfg_err    (cfg_err),
        .current    (current),
        .active     (active)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic straight from the behavioural rules
    int m_w[N];
    int m_cur  = 0;
    bit m_busy = 1'b1;
    bit m_err  = 1'b0;

    always @(posedge clk) begin
        int  s;
        bit  acc;
        exp_t e;
        if (!rst_n) begin
            foreach (m_w[i]) m_w[i] = 0;
            m_cur  = 0;
            m_busy = 1'b1;
            m_err  = 1'b0;
        end else begin
            acc = cfg_valid && !m_busy;
            if (en) begin
                s = m_cur / (1 << DS);
                for (int i = 0; i < N; i++) if (spikes_in[i]) s += m_w[i];
                m_cur = (s > 255) ? 255 : s;
            end
            m_err = acc && (int'(cfg_addr) >= N);
            if (acc && int'(cfg_addr) < N) m_w[int'(cfg_addr)] = int'(cfg_weight);
            m_busy = acc;
        end
        e.cur = m_cur;
        e.act = (m_cur != 0);
        e.rdy = !m_busy;
        e.err = m_err;
        exp_q.push_back(e);
    end

    // Monitor: pops one expectation per edge and compares all outputs
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (int'(current) != e.cur || active != e.act ||
                cfg_ready != e.rdy || cfg_err != e.err) begin
                n_bad++;
                $display("FAIL outputs t=%0t: got cur=%0d act=%0b rdy=%0b err=%0b, want cur=%0d act=%0b rdy=%0b err=%0b",
                         $time, current, active, cfg_ready, cfg_err, e.cur, e.act, e.rdy, e.err);
            end
        end
    end

    task automatic check_cur(input string name, input int want);
        n_cmp++;
        if (int'(current) != want) begin
            n_bad++;
            $display("FAIL %s: current=%0d want=%0d", name, current, want);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Holds a request until accepted, bounded so a stuck ready cannot hang the run
    task automatic do_write(input int a, input int w);
        bit acc = 1'b0;
        cfg_valid  = 1'b1;
        cfg_addr   = 3'(a);
        cfg_weight = 8'(w);
        for (int k = 0; k < 10 && !acc; k++) begin
            acc = cfg_ready;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_timeout: addr=%0d never accepted", a);
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 10 && !cfg_ready; k++) @(negedge clk);
    endtask

    initial begin
        int dec[7];
        dec = '{40, 20, 10, 5, 2, 1, 0};
        rst_n = 1'b0; en = 1'b0; spikes_in = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_weight = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // decay of a single pulse
        do_write(2, 40);
        en = 1'b1;
        spikes_in = N'(4);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            spikes_in = '0;
            check_cur("decay", dec[i]);
        end

        // same-cycle write and spike use the old weight
        do_write(0, 50);
        wait_ready();
        cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_weight = 8'd10; spikes_in = N'(1);
        @(negedge clk);
        check_cur("collision_old", 50);
        cfg_valid = 1'b0;
        @(negedge clk);
        check_cur("collision_new", 35);
        spikes_in = '0;
        tick(10);

        // held valid: two accepts two cycles apart
        wait_ready();
        cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_weight = 8'd5;
        @(negedge clk);
        cfg_addr = 3'd3; cfg_weight = 8'd7;
        tick(2);
        cfg_valid = 1'b0;
        tick(2);

        // illegal addresses
        do_write(7, 99);
        do_write(6, 99);
        tick(2);

        // saturation then release
        for (int i = 0; i < N; i++) do_write(i, 200);
        spikes_in = '1;
        tick(5);
        check_cur("saturate", 255);
        spikes_in = '0;
        @(negedge clk);
        check_cur("sat_release", 127);
        @(negedge clk);
        check_cur("sat_release2", 63);

        // disabled: current holds despite spikes
        en = 1'b0;
        spikes_in = '1;
        tick(4);
        check_cur("en_hold", 63);
        en = 1'b1;

        // reset mid-operation, then spike yields zero
        rst_n = 1'b0;
        @(negedge clk);
        check_cur("reset_mid", 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_cur("reset_weights", 0);
        spikes_in = '0;
        tick(2);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            en         = ($urandom_range(0, 3) != 0);
            spikes_in  = N'($urandom);
            if ($urandom_range(0, 2) == 0) spikes_in = '0;
            cfg_valid  = ($urandom_range(0, 1) == 1);
            cfg_addr   = 3'($urandom);
            cfg_weight = 8'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1; cfg_valid = 1'b0; spikes_in = '0;
        tick(3);

        n_cmp++;
        if (exp_q.size() > 1) begin
            n_bad++;
            $display("FAIL drain: %0d expectations pending, want at most 1", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
